// File: rtl/rolhas_pkg.sv
// Shared definitions for the cork-supply stage: FSM encoding, count width,
// default capacities and a small min-of-three helper.
package rolhas_pkg;

    localparam int CNT_W = 7;

    localparam int DEF_MAX_PRIM  = 99;
    localparam int DEF_MAX_SEC   = 99;
    localparam int DEF_MIN_LEVEL = 5;
    localparam int DEF_BATCH     = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRANSFER = 2'b01,
        SETTLE   = 2'b10
    } state_t;

    function automatic logic [CNT_W-1:0] min3(input logic [CNT_W-1:0] a,
                                             input logic [CNT_W-1:0] b,
                                             input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/rolhas_bin7_to_bcd.sv
// Binary (0..127) to tens/units BCD converter for the primary cork count.
// Only present in builds with ROLHAS_BCD_OUT_EN defined.
`ifdef ROLHAS_BCD_OUT_EN
module rolhas_bin7_to_bcd
    import rolhas_pkg::*;
(
    input  logic [CNT_W-1:0] bin,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    logic [CNT_W-1:0] rem;

    // Repeated subtraction of ten; twelve steps cover the full 7-bit range.
    always_comb begin
        tens = '0;
        rem  = bin;
        for (int i = 0; i < 12; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        units = rem[3:0];
    end

endmodule
`endif

// File: rtl/rolhas_transfer_ctrl.sv
// Cork-supply stage: operator-loaded reservoir feeding a primary buffer one cork
// per clock. Optional BCD outputs of the primary count under ROLHAS_BCD_OUT_EN.
module rolhas_transfer_ctrl
    import rolhas_pkg::*;
#(
    parameter int MAX_PRIM  = DEF_MAX_PRIM,
    parameter int MAX_SEC   = DEF_MAX_SEC,
    parameter int MIN_LEVEL = DEF_MIN_LEVEL,
    parameter int BATCH     = DEF_BATCH
)(
    input  logic             clk,
    input  logic             Nclr,
    input  logic             load_req,
    input  logic [CNT_W-1:0] load_qty,
    input  logic             consume,
    input  logic             refill_en,
    output logic [CNT_W-1:0] buffer_principal,
    output logic [CNT_W-1:0] buffer_secundario,
    output logic             ro,
    output logic             min_signal,
    output logic             busy,
    output logic             load_err,
    output logic             consume_err
`ifdef ROLHAS_BCD_OUT_EN
    ,
    output logic [3:0]       reg_rd,
    output logic [3:0]       reg_ru
`endif
);

    localparam logic [CNT_W-1:0] MAX_PRIM_C  = CNT_W'(MAX_PRIM);
    localparam logic [CNT_W:0]   MAX_SEC_C   = (CNT_W+1)'(MAX_SEC);
    localparam logic [CNT_W-1:0] MIN_LEVEL_C = CNT_W'(MIN_LEVEL);
    localparam logic [CNT_W-1:0] BATCH_C     = CNT_W'(BATCH);

    state_t           state;
    logic [CNT_W-1:0] prim;
    logic [CNT_W-1:0] sec;
    logic [CNT_W-1:0] remaining;

    logic [CNT_W:0]   load_sum;
    logic             load_ok;
    logic             move;
    logic [CNT_W-1:0] sec_loaded;
    logic [CNT_W-1:0] sec_next;

    // The overflow check is done at 8 bits on the pre-decrement reservoir.
    assign load_sum   = {1'b0, sec} + {1'b0, load_qty};
    assign load_ok    = load_req && (load_sum <= MAX_SEC_C);
    assign move       = (state == TRANSFER) && (remaining != '0) && (sec != '0);
    assign sec_loaded = load_ok ? load_sum[CNT_W-1:0] : sec;
    assign sec_next   = sec_loaded - CNT_W'(move);

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            prim        <= '0;
            sec         <= '0;
            load_err    <= 1'b0;
            consume_err <= 1'b0;
        end else begin
            sec         <= sec_next;
            load_err    <= load_req && !load_ok;
            consume_err <= consume && (prim == '0) && !move;
            // A move and a consume in the same cycle cancel out on the primary.
            if (move && !consume)
                prim <= prim + 1'b1;
            else if (!move && consume && (prim != '0))
                prim <= prim - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (refill_en && (prim < MIN_LEVEL_C) && (sec != '0)) begin
                        state     <= TRANSFER;
                        busy      <= 1'b1;
                        remaining <= min3(BATCH_C, sec, MAX_PRIM_C - prim);
                    end
                end
                TRANSFER: begin
                    remaining <= remaining - 1'b1;
                    if ((remaining <= 7'd1) || (sec_next == '0) || !refill_en) begin
                        state <= SETTLE;
                        busy  <= 1'b0;
                    end
                end
                SETTLE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign buffer_principal  = prim;
    assign buffer_secundario = sec;
    assign ro                = (prim == '0);
    assign min_signal        = (prim < MIN_LEVEL_C);

`ifdef ROLHAS_BCD_OUT_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;

    rolhas_bin7_to_bcd u_bcd (
        .bin   (prim),
        .tens  (bcd_tens),
        .units (bcd_units)
    );

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            reg_rd <= '0;
            reg_ru <= '0;
        end else begin
            reg_rd <= bcd_tens;
            reg_ru <= bcd_units;
        end
    end
`endif

endmodule

// File: tb/tb_rolhas_transfer_ctrl.sv
// Directed self-checking bench for rolhas_transfer_ctrl; BCD outputs are
// checked only when ROLHAS_BCD_OUT_EN is defined.
module tb_rolhas_transfer_ctrl;

    logic       clk = 1'b0;
    logic       Nclr;
    logic       load_req;
    logic [6:0] load_qty;
    logic       consume;
    logic       refill_en;
    logic [6:0] buffer_principal;
    logic [6:0] buffer_secundario;
    logic       ro;
    logic       min_signal;
    logic       busy;
    logic       load_err;
    logic       consume_err;
`ifdef ROLHAS_BCD_OUT_EN
    logic [3:0] reg_rd;
    logic [3:0] reg_ru;
`endif

    int tests = 0;
    int fails = 0;
    int busy_cnt;

    rolhas_transfer_ctrl dut (
        .clk               (clk),
        .Nclr              (Nclr),
        .load_req          (load_req),
        .load_qty          (load_qty),
        .consume           (consume),
        .refill_en         (refill_en),
        .buffer_principal  (buffer_principal),
        .buffer_secundario (buffer_secundario),
        .ro                (ro),
        .min_signal        (min_signal),
        .busy              (busy),
        .load_err          (load_err),
        .consume_err       (consume_err)
`ifdef ROLHAS_BCD_OUT_EN
        ,
        .reg_rd            (reg_rd),
        .reg_ru            (reg_ru)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lr, input logic [6:0] qty,
                                 input logic cons, input logic ren);
        load_req  = lr;
        load_qty  = qty;
        consume   = cons;
        refill_en = ren;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Nclr      = 1'b0;
        load_req  = 1'b0;
        load_qty  = '0;
        consume   = 1'b0;
        refill_en = 1'b0;
        #2;
        checkOutput("rst_prim", 8'(buffer_principal), 8'd0);
        checkOutput("rst_sec", 8'(buffer_secundario), 8'd0);
        checkOutput("rst_ro", 8'(ro), 8'd1);
        checkOutput("rst_min", 8'(min_signal), 8'd1);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        checkOutput("rst_lerr", 8'(load_err), 8'd0);
        checkOutput("rst_cerr", 8'(consume_err), 8'd0);
        #20;
        Nclr = 1'b1;

        // Load 30 and refill one 20-cork burst
        applyStimulus(1'b1, 7'd30, 1'b0, 1'b1);
        load_req = 1'b0;
        checkOutput("t1_sec_load", 8'(buffer_secundario), 8'd30);
        checkOutput("t1_busy_pre", 8'(busy), 8'd0);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (i == 0) begin
                checkOutput("t1_busy_entry", 8'(busy), 8'd1);
                checkOutput("t1_ro_entry", 8'(ro), 8'd1);
            end
            if (i == 1) begin
                checkOutput("t1_prim_first", 8'(buffer_principal), 8'd1);
                checkOutput("t1_ro_first", 8'(ro), 8'd0);
                checkOutput("t1_sec_first", 8'(buffer_secundario), 8'd29);
            end
        end
        checkOutput("t1_busy_cycles", 8'(busy_cnt), 8'd20);
        checkOutput("t1_prim_end", 8'(buffer_principal), 8'd20);
        checkOutput("t1_sec_end", 8'(buffer_secundario), 8'd10);
        checkOutput("t1_busy_end", 8'(busy), 8'd0);
        checkOutput("t1_min_end", 8'(min_signal), 8'd0);
`ifdef ROLHAS_BCD_OUT_EN
        checkOutput("t1_bcd_rd", 8'(reg_rd), 8'd2);
        checkOutput("t1_bcd_ru", 8'(reg_ru), 8'd0);
`endif

        // Consume down to 4 with refill disabled
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
        consume = 1'b0;
        checkOutput("t5_prim_low", 8'(buffer_principal), 8'd4);
        checkOutput("t5_min_low", 8'(min_signal), 8'd1);
        applyStimulus(1'b1, 7'd60, 1'b0, 1'b0);
        checkOutput("t5_sec_load", 8'(buffer_secundario), 8'd70);

        // Burst with consume overlap, a concurrent load, then early stop
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("t5_busy_entry", 8'(busy), 8'd1);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b1);
        checkOutput("t5_prim_c1", 8'(buffer_principal), 8'd4);
        checkOutput("t5_sec_c1", 8'(buffer_secundario), 8'd69);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b1);
        checkOutput("t5_sec_c2", 8'(buffer_secundario), 8'd68);
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b1);
        checkOutput("t5_prim_c3", 8'(buffer_principal), 8'd4);
        checkOutput("t5_sec_c3", 8'(buffer_secundario), 8'd67);
        checkOutput("t5_cerr_c3", 8'(consume_err), 8'd0);
        applyStimulus(1'b1, 7'd10, 1'b0, 1'b1);
        checkOutput("t5_prim_ld", 8'(buffer_principal), 8'd5);
        checkOutput("t5_sec_ld", 8'(buffer_secundario), 8'd76);
        checkOutput("t5_min_five", 8'(min_signal), 8'd0);
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
        checkOutput("t5_prim_f", 8'(buffer_principal), 8'd6);
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("t5_prim_last", 8'(buffer_principal), 8'd7);
        checkOutput("t5_sec_last", 8'(buffer_secundario), 8'd74);
        checkOutput("t5_busy_drop", 8'(busy), 8'd0);
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("t5_prim_idle", 8'(buffer_principal), 8'd7);
        checkOutput("t5_sec_idle", 8'(buffer_secundario), 8'd74);
`ifdef ROLHAS_BCD_OUT_EN
        checkOutput("t5_bcd_rd", 8'(reg_rd), 8'd0);
        checkOutput("t5_bcd_ru", 8'(reg_ru), 8'd7);
`endif

        // Reservoir overflow rejection
        applyStimulus(1'b1, 7'd26, 1'b0, 1'b0);
        checkOutput("t3_lerr_over", 8'(load_err), 8'd1);
        checkOutput("t3_sec_over", 8'(buffer_secundario), 8'd74);
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("t3_lerr_pulse", 8'(load_err), 8'd0);
        applyStimulus(1'b1, 7'd25, 1'b0, 1'b0);
        checkOutput("t3_sec_full", 8'(buffer_secundario), 8'd99);
        checkOutput("t3_lerr_full", 8'(load_err), 8'd0);
        applyStimulus(1'b1, 7'd0, 1'b0, 1'b0);
        checkOutput("t3_sec_zero", 8'(buffer_secundario), 8'd99);
        checkOutput("t3_lerr_zero", 8'(load_err), 8'd0);
        applyStimulus(1'b1, 7'd127, 1'b0, 1'b0);
        checkOutput("t3_lerr_wrap", 8'(load_err), 8'd1);
        checkOutput("t3_sec_wrap", 8'(buffer_secundario), 8'd99);
        load_req = 1'b0;

        // Consume on an empty primary
        #2;
        Nclr = 1'b0;
        #1;
        checkOutput("t4_rst_prim", 8'(buffer_principal), 8'd0);
        #3;
        Nclr = 1'b1;
        applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
        checkOutput("t4_cerr", 8'(consume_err), 8'd1);
        checkOutput("t4_prim", 8'(buffer_principal), 8'd0);
        checkOutput("t4_ro", 8'(ro), 8'd1);
        checkOutput("t4_min", 8'(min_signal), 8'd1);
        applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
        checkOutput("t4_cerr_pulse", 8'(consume_err), 8'd0);

        // Asynchronous reset in the middle of a burst
        applyStimulus(1'b1, 7'd30, 1'b0, 1'b1);
        load_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t6_prim_mid", 8'(buffer_principal), 8'd3);
        checkOutput("t6_busy_mid", 8'(busy), 8'd1);
        #2;
        Nclr = 1'b0;
        #1;
        checkOutput("t6_prim_rst", 8'(buffer_principal), 8'd0);
        checkOutput("t6_sec_rst", 8'(buffer_secundario), 8'd0);
        checkOutput("t6_busy_rst", 8'(busy), 8'd0);
        checkOutput("t6_ro_rst", 8'(ro), 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
